// File: rtl/roce_pkg.sv
// Shared RoCE RC constants, field widths, FSM state type and PMTU legality check.
// Latency: none (declarations only).
// Backpressure: not applicable.
package roce_pkg;

  localparam int PSN_W = 24;
  localparam int QPN_W = 24;

  localparam logic [7:0] RC_RDMA_WRITE_FIRST  = 8'h06;
  localparam logic [7:0] RC_RDMA_WRITE_MIDDLE = 8'h07;
  localparam logic [7:0] RC_RDMA_WRITE_LAST   = 8'h08;
  localparam logic [7:0] RC_RDMA_WRITE_ONLY   = 8'h0A;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } seg_state_t;

  // Path MTU payload must be a power of two between 256 and 4096 bytes.
  function automatic bit pmtu_legal(input int pmtu);
    return (pmtu == 256) || (pmtu == 512) || (pmtu == 1024) ||
           (pmtu == 2048) || (pmtu == 4096);
  endfunction

endpackage

// File: rtl/roce_write_segmenter_64.sv
// Splits one RDMA WRITE into PMTU-sized RC packet descriptors and tracks the next PSN per QP.
// Latency: first descriptor valid one cycle after the start edge; one descriptor per cycle thereafter.
// Backpressure: valid/ready; all descriptor fields hold while valid && !ready, starts arriving while busy are dropped.
module roce_write_segmenter_64
  import roce_pkg::*;
#(
  parameter int PMTU_BYTES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_start_transfer,
  input  logic [31:0]      s_dma_length,
  input  logic [31:0]      s_r_key,
  input  logic [QPN_W-1:0] s_rem_qpn,
  input  logic [PSN_W-1:0] s_loc_psn,
  input  logic [31:0]      s_rem_ip_addr,
  input  logic [63:0]      s_rem_addr,
  output logic             m_desc_valid,
  input  logic             m_desc_ready,
  output logic [7:0]       m_desc_opcode,
  output logic [PSN_W-1:0] m_desc_psn,
  output logic [QPN_W-1:0] m_desc_dest_qpn,
  output logic [31:0]      m_desc_rem_ip_addr,
  output logic [63:0]      m_desc_rem_addr,
  output logic [31:0]      m_desc_r_key,
  output logic [31:0]      m_desc_dma_length,
  output logic [15:0]      m_desc_payload_len,
  output logic [PSN_W-1:0] next_psn,
  output logic             transfer_done,
  output logic             start_dropped,
  output logic             busy
);

  generate
    if (!pmtu_legal(PMTU_BYTES)) begin : g_bad_pmtu
      $error("PMTU_BYTES must be a power of two between 256 and 4096");
    end
  endgenerate

  localparam logic [31:0] PMTU_LEN = 32'(PMTU_BYTES);
  localparam logic [15:0] PMTU_PAY = 16'(PMTU_BYTES);

  // Payload of a packet given the bytes still to send, including this packet.
  function automatic logic [15:0] pay_of(input logic [31:0] rem);
    return (rem <= PMTU_LEN) ? rem[15:0] : PMTU_PAY;
  endfunction

  seg_state_t       r_state;
  seg_state_t       w_state_nxt;
  logic             r_start_d;
  logic             r_psn_init;
  logic [31:0]      r_remaining;
  logic [PSN_W-1:0] r_next_psn;
  logic             r_valid;
  logic [7:0]       r_opcode;
  logic [PSN_W-1:0] r_psn;
  logic [QPN_W-1:0] r_qpn;
  logic [31:0]      r_ip;
  logic [63:0]      r_addr;
  logic [31:0]      r_key;
  logic [31:0]      r_len;
  logic [15:0]      r_pay;
  logic             r_done;
  logic             r_dropped;
  logic             r_busy;

  logic             w_start_edge;
  logic             w_accept;
  logic             w_cur_last;
  logic             w_load;
  logic             w_fin;
  logic             w_drop;
  logic [PSN_W-1:0] w_base_psn;
  logic [31:0]      w_rem_nxt;
  logic [63:0]      w_addr_nxt;

  assign w_start_edge = s_start_transfer & ~r_start_d;
  assign w_accept     = r_valid & m_desc_ready;
  // remaining still counts the packet on the bus, so it is the last one when it fits in one PMTU
  assign w_cur_last   = (r_remaining <= PMTU_LEN);
  assign w_base_psn   = r_psn_init ? r_next_psn : s_loc_psn;
  assign w_rem_nxt    = r_remaining - {16'd0, r_pay};
  assign w_addr_nxt   = r_addr + {48'd0, r_pay};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes: load a new transfer, finish on last accept, drop busy starts.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_fin       = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_drop = w_start_edge;
        if (w_accept && w_cur_last) begin
          w_fin       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Descriptor registers, PSN tracking and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_d   <= 1'b1;
      r_psn_init  <= 1'b0;
      r_remaining <= '0;
      r_next_psn  <= '0;
      r_valid     <= 1'b0;
      r_opcode    <= '0;
      r_psn       <= '0;
      r_qpn       <= '0;
      r_ip        <= '0;
      r_addr      <= '0;
      r_key       <= '0;
      r_len       <= '0;
      r_pay       <= '0;
      r_done      <= 1'b0;
      r_dropped   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_start_d <= s_start_transfer;
      r_done    <= w_fin;
      r_dropped <= w_drop;
      r_busy    <= (w_state_nxt != ST_IDLE);
      if (w_load) begin
        r_psn_init  <= 1'b1;
        r_valid     <= 1'b1;
        r_qpn       <= s_rem_qpn;
        r_ip        <= s_rem_ip_addr;
        r_key       <= s_r_key;
        r_len       <= s_dma_length;
        r_psn       <= w_base_psn;
        r_addr      <= s_rem_addr;
        r_remaining <= s_dma_length;
        r_pay       <= pay_of(s_dma_length);
        r_opcode    <= (s_dma_length <= PMTU_LEN) ? RC_RDMA_WRITE_ONLY : RC_RDMA_WRITE_FIRST;
      end else if (w_fin) begin
        r_valid    <= 1'b0;
        r_next_psn <= r_psn + 24'd1;
      end else if (w_accept) begin
        r_psn       <= r_psn + 24'd1;
        r_addr      <= w_addr_nxt;
        r_remaining <= w_rem_nxt;
        r_pay       <= pay_of(w_rem_nxt);
        r_opcode    <= (w_rem_nxt <= PMTU_LEN) ? RC_RDMA_WRITE_LAST : RC_RDMA_WRITE_MIDDLE;
      end
    end
  end

  assign m_desc_valid       = r_valid;
  assign m_desc_opcode      = r_opcode;
  assign m_desc_psn         = r_psn;
  assign m_desc_dest_qpn    = r_qpn;
  assign m_desc_rem_ip_addr = r_ip;
  assign m_desc_rem_addr    = r_addr;
  assign m_desc_r_key       = r_key;
  assign m_desc_dma_length  = r_len;
  assign m_desc_payload_len = r_pay;
  assign next_psn           = r_next_psn;
  assign transfer_done      = r_done;
  assign start_dropped      = r_dropped;
  assign busy               = r_busy;

endmodule

// File: tb/tb_roce_write_segmenter_64.sv
// Bench for the RDMA WRITE segmenter: expected descriptor lists built per transfer from packet arithmetic.
// Latency: descriptors compared at every accepted handshake, stall stability checked every stalled cycle.
// Backpressure: ready driven always-on, toggling, random or manually.
module tb_roce_write_segmenter_64;
  import roce_pkg::*;

  localparam int PMTU = 1024;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] psn;
    logic [23:0] qpn;
    logic [31:0] ip;
    logic [63:0] addr;
    logic [31:0] key;
    logic [31:0] len;
    logic [15:0] pay;
  } desc_t;

  logic        clk;
  logic        rst_n = 1'b0;
  logic        s_start_transfer = 1'b0;
  logic [31:0] s_dma_length = '0;
  logic [31:0] s_r_key = '0;
  logic [23:0] s_rem_qpn = '0;
  logic [23:0] s_loc_psn = '0;
  logic [31:0] s_rem_ip_addr = '0;
  logic [63:0] s_rem_addr = '0;
  logic        m_desc_valid;
  logic        m_desc_ready = 1'b0;
  logic [7:0]  m_desc_opcode;
  logic [23:0] m_desc_psn;
  logic [23:0] m_desc_dest_qpn;
  logic [31:0] m_desc_rem_ip_addr;
  logic [63:0] m_desc_rem_addr;
  logic [31:0] m_desc_r_key;
  logic [31:0] m_desc_dma_length;
  logic [15:0] m_desc_payload_len;
  logic [23:0] next_psn;
  logic        transfer_done;
  logic        start_dropped;
  logic        busy;

  roce_write_segmenter_64 #(.PMTU_BYTES(PMTU)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_start_transfer(s_start_transfer), .s_dma_length(s_dma_length), .s_r_key(s_r_key),
    .s_rem_qpn(s_rem_qpn), .s_loc_psn(s_loc_psn), .s_rem_ip_addr(s_rem_ip_addr),
    .s_rem_addr(s_rem_addr),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready), .m_desc_opcode(m_desc_opcode),
    .m_desc_psn(m_desc_psn), .m_desc_dest_qpn(m_desc_dest_qpn),
    .m_desc_rem_ip_addr(m_desc_rem_ip_addr), .m_desc_rem_addr(m_desc_rem_addr),
    .m_desc_r_key(m_desc_r_key), .m_desc_dma_length(m_desc_dma_length),
    .m_desc_payload_len(m_desc_payload_len), .next_psn(next_psn),
    .transfer_done(transfer_done), .start_dropped(start_dropped), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  desc_t exp_q[$];
  bit m_init = 1'b0;
  logic [23:0] m_next = '0;
  int ready_mode = 0;
  logic manual_rdy = 1'b0;
  logic tog = 1'b0;
  logic [7:0]  last_op = '0;
  logic [23:0] last_psn = '0;
  logic [15:0] last_pay = '0;
  desc_t act, held, e_pop;
  bit prev_stall = 1'b0;

  task automatic chk(input string name, input logic [255:0] a, input logic [255:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, a, x);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ready pattern applied just after each rising edge
  always begin
    @(posedge clk);
    #1;
    tog = ~tog;
    case (ready_mode)
      0: m_desc_ready = 1'b1;
      1: m_desc_ready = tog;
      2: m_desc_ready = 1'($urandom_range(0, 1));
      default: m_desc_ready = manual_rdy;
    endcase
  end

  // compare process: every handshake against the expected list, every stall against the held value
  always @(negedge clk) begin
    act = {m_desc_opcode, m_desc_psn, m_desc_dest_qpn, m_desc_rem_ip_addr, m_desc_rem_addr,
           m_desc_r_key, m_desc_dma_length, m_desc_payload_len};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {m_desc_valid, act}, {1'b1, held});
      if (m_desc_valid && m_desc_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_desc actual=%0h required=none", act);
        end else begin
          e_pop = exp_q.pop_front();
          chk("desc", act, e_pop);
          last_op  = m_desc_opcode;
          last_psn = m_desc_psn;
          last_pay = m_desc_payload_len;
        end
      end
      prev_stall = m_desc_valid && !m_desc_ready;
      held = act;
      if (transfer_done) done_cnt++;
      if (start_dropped) drop_cnt++;
    end
  end

  // Drive the request fields and append the expected packet list for this transfer.
  task automatic load_xfer(input logic [31:0] len, input logic [23:0] lpsn, input logic [63:0] addr);
    logic [23:0] base;
    logic [63:0] npk, off, left;
    desc_t e;
    s_dma_length  = len;
    s_loc_psn     = lpsn;
    s_rem_addr    = addr;
    s_r_key       = $urandom;
    s_rem_qpn     = 24'($urandom);
    s_rem_ip_addr = $urandom;
    base = m_init ? m_next : lpsn;
    npk  = (len == 0) ? 64'd1 : (64'(len) + 64'(PMTU) - 64'd1) / 64'(PMTU);
    for (int k = 0; k < int'(npk); k++) begin
      off   = 64'(k) * 64'(PMTU);
      left  = 64'(len) - off;
      e.pay = (left >= 64'(PMTU)) ? 16'(PMTU) : 16'(left);
      if (npk == 1)                 e.op = 8'h0A;
      else if (k == 0)              e.op = 8'h06;
      else if (64'(k) == npk - 1)   e.op = 8'h08;
      else                          e.op = 8'h07;
      e.psn  = base + 24'(k);
      e.qpn  = s_rem_qpn;
      e.ip   = s_rem_ip_addr;
      e.addr = addr + off;
      e.key  = s_r_key;
      e.len  = len;
      exp_q.push_back(e);
    end
    m_init = 1'b1;
    m_next = base + 24'(npk);
  endtask

  task automatic run_xfer(input logic [31:0] len, input logic [23:0] lpsn, input logic [63:0] addr,
                          input int mode, input int hold, input bit drop_test);
    int d0, dr0, c;
    load_xfer(len, lpsn, addr);
    ready_mode = mode;
    d0  = done_cnt;
    dr0 = drop_cnt;
    s_start_transfer = 1'b1;
    c = 0;
    while (1) begin
      tick();
      c++;
      if (drop_test && c == 3) begin
        s_start_transfer = 1'b0;
        s_r_key   = $urandom;
        s_rem_qpn = 24'($urandom);
        s_rem_addr = {$urandom, $urandom};
        s_dma_length = $urandom;
      end
      if (drop_test && c == 4) s_start_transfer = 1'b1;
      if (c >= hold && exp_q.size() == 0 && done_cnt > d0) break;
      if (c >= 5000) begin
        total++;
        bad++;
        $display("FAIL xfer_timeout actual=%0d_left required=0", exp_q.size());
        break;
      end
    end
    s_start_transfer = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("done_once", done_cnt, d0 + 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("drop_count", drop_cnt, dr0 + (drop_test ? 1 : 0));
    chk("busy_idle", {busy, m_desc_valid}, 2'b00);
    chk("next_psn", next_psn, m_next);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    m_init = 1'b0;
    m_next = '0;
    rst_n = 1'b1;
  endtask

  logic [31:0] rlen;
  logic [63:0] raddr;

  initial begin
    // reset with start already high: must not trigger after release
    s_start_transfer = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_state",
        {m_desc_valid, transfer_done, start_dropped, busy, next_psn, m_desc_opcode, m_desc_psn,
         m_desc_dest_qpn, m_desc_rem_ip_addr, m_desc_rem_addr, m_desc_r_key, m_desc_dma_length,
         m_desc_payload_len}, '0);
    rst_n = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("no_trigger_at_release", {busy, m_desc_valid}, 2'b00);
    s_start_transfer = 1'b0;
    repeat (2) tick();

    // zero length -> single ONLY with payload 0
    run_xfer(32'd0, 24'h000010, 64'h1000, 0, 0, 0);
    chk("len0_op", last_op, 8'h0A);
    chk("len0_psn", last_psn, 24'h000010);
    chk("len0_pay", last_pay, 16'd0);
    chk("len0_next", next_psn, 24'h000011);

    run_xfer(32'd1024, 24'h777777, 64'h2000, 0, 0, 0);
    chk("len1024_op", last_op, 8'h0A);
    chk("len1024_pay", last_pay, 16'd1024);
    chk("len1024_psn", last_psn, 24'h000011);

    run_xfer(32'd1025, 24'h777777, 64'h3000, 0, 0, 0);
    chk("len1025_op", last_op, 8'h08);
    chk("len1025_pay", last_pay, 16'd1);

    run_xfer(32'd3072, 24'h0, 64'h4000, 1, 0, 0);
    chk("len3072_op", last_op, 8'h08);

    // PSN wraparound from a fresh reset
    do_reset();
    repeat (2) tick();
    run_xfer(32'd3000, 24'hFFFFFE, 64'hFFFF_FFFF_FFFF_FC00, 0, 0, 0);
    chk("wrap_last_psn", last_psn, 24'h000000);
    chk("wrap_next", next_psn, 24'h000001);
    run_xfer(32'd100, 24'h000555, 64'h5000, 0, 0, 0);
    chk("second_base_psn", last_psn, 24'h000001);

    // level held high for 20 cycles -> one transfer only
    run_xfer(32'd200, 24'h0, 64'h6000, 0, 20, 0);
    // new edge while issuing -> dropped, stream untouched
    run_xfer(32'd12288, 24'h0, 64'h7000, 2, 0, 1);

    // randomized transfers
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 6))
        0: rlen = 32'd0;
        1: rlen = 32'd1;
        2: rlen = 32'(PMTU - 1);
        3: rlen = 32'(PMTU);
        4: rlen = 32'(PMTU + 1);
        5: rlen = 32'(2 * PMTU);
        default: rlen = $urandom_range(0, 6 * PMTU);
      endcase
      raddr = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) raddr[63:16] = 48'hFFFF_FFFF_FFFF;
      run_xfer(rlen, 24'($urandom), raddr, $urandom_range(0, 2), 0, 0);
    end

    // reset while a MIDDLE descriptor is stalled
    ready_mode = 3;
    manual_rdy = 1'b0;
    repeat (2) tick();
    load_xfer(32'd4096, 24'h000100, 64'h8000);
    s_start_transfer = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    manual_rdy = 1'b1;
    @(negedge clk);
    manual_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("stalled_middle", {m_desc_valid, m_desc_opcode}, {1'b1, 8'h07});
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_abandon", {m_desc_valid, busy}, 2'b00);
    chk("reset_next_psn", next_psn, 24'h0);
    exp_q.delete();
    m_init = 1'b0;
    m_next = '0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_retrigger", {m_desc_valid, busy}, 2'b00);
    s_start_transfer = 1'b0;
    ready_mode = 0;
    repeat (2) tick();
    run_xfer(32'd500, 24'h000ABC, 64'h9000, 0, 0, 0);
    chk("psn_init_cleared", last_psn, 24'h000ABC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/roce_write_segmenter_64.md
Name: roce_write_segmenter_64

Overview:
- Sits directly downstream of the UDP RoCE connection manager and consumes its QP parameters plus the start_transfer level.
- On each new start request, segments one RDMA WRITE of dma_transfer bytes into PMTU-sized packet descriptors: opcode, PSN, remote address, payload length.
- Descriptors feed the RoCE TX header/payload generator over a valid/ready handshake.
- Tracks the next PSN across transfers on the same QP.

Parameters:
- PMTU_BYTES, 1024: path MTU payload bytes. Legal values are powers of two from 256 to 4096; any other value is an elaboration error.

Ports:
- clk  in  1  sole clock
- rst_n  in  1  synchronous, active-low reset
- s_start_transfer  in  1  level from the manager (start & metadata_valid); only a rising edge triggers a transfer
- s_dma_length  in  32  total transfer bytes
- s_r_key  in  32  remote key
- s_rem_qpn  in  24  destination QPN
- s_loc_psn  in  24  starting PSN, used for the first transfer after reset
- s_rem_ip_addr  in  32  destination IP
- s_rem_addr  in  64  remote virtual start address
- m_desc_valid  out  1  descriptor valid
- m_desc_ready  in  1  downstream accepts
- m_desc_opcode  out  8  RC write opcode
- m_desc_psn  out  24  packet PSN
- m_desc_dest_qpn  out  24  latched QPN
- m_desc_rem_ip_addr  out  32  latched IP
- m_desc_rem_addr  out  64  start address + bytes already issued
- m_desc_r_key  out  32  latched key
- m_desc_dma_length  out  32  total transfer length, for RETH
- m_desc_payload_len  out  16  bytes in this packet
- next_psn  out  24  PSN the next transfer will use
- transfer_done  out  1  one-cycle pulse on last descriptor accept
- start_dropped  out  1  one-cycle pulse when a rising edge arrives while busy
- busy  out  1  high while not IDLE

Behaviour:
- Reset values, while rst_n=0 at a clk edge:
  - m_desc_valid, transfer_done, start_dropped, busy = 0.
  - All m_desc_* data outputs = 0.
  - next_psn = 0; psn_init flag cleared.
  - Start edge detector history = 1, so a level already high at reset release does not trigger.
- Start edge: start_edge = s_start_transfer & ~start_d.
- States: IDLE, ISSUE.
- IDLE, on start_edge (cycle N):
  - Latch all s_* inputs.
  - Base PSN = s_loc_psn if psn_init is clear, else next_psn; then set psn_init.
  - remaining = s_dma_length.
  - Go to ISSUE. m_desc_valid = 1 at N+1, with the first descriptor registered.
- Descriptor content:
  - payload_len = min(remaining, PMTU_BYTES).
  - Opcodes: first && remaining<=PMTU -> ONLY 0x0A; first -> FIRST 0x06; remaining<=PMTU -> LAST 0x08; otherwise MIDDLE 0x07.
  - Length 0 gives a single ONLY descriptor with payload_len 0.
- Handshake:
  - All m_desc_* outputs hold stable while m_desc_valid && !m_desc_ready.
  - Valid never drops without an accept.
  - On accept: psn += 1 (mod 2^24, 0xFFFFFF wraps to 0); rem_addr += payload_len (64-bit wrap); remaining -= payload_len.
  - The next descriptor is presented in the cycle after accept, so back-to-back acceptance is 1 descriptor/cycle while ready stays high.
- Last accept (LAST or ONLY):
  - transfer_done pulses in the following cycle.
  - next_psn = psn+1 (wrapped); state returns to IDLE; m_desc_valid = 0.
  - A start_edge in that same cycle is treated as busy and dropped.
- start_edge while in ISSUE: the edge is ignored and start_dropped pulses; latched fields are unchanged.
- busy = (state != IDLE), registered.
- Reset mid-transfer: the descriptor is abandoned immediately, valid = 0, and psn_init is cleared.
- Packet count = ceil(len/PMTU), computed incrementally from the remaining counter; no divider.

Decomposition:
- Shared package roce_pkg holds:
  - the RC opcode constants (RC_RDMA_WRITE_FIRST/MIDDLE/LAST/ONLY);
  - PSN width 24 and QPN width 24;
  - the PMTU legality check function.
- No sub-module; an FSM plus counters fits in about 200 lines.

Test Plan:
- len=0, loc_psn=0x000010 -> one desc: opcode 0x0A, payload 0, psn 0x10; next_psn=0x11.
- len=1024 -> one ONLY, payload 1024. len=1025 -> FIRST (1024, psn p), then LAST (1, psn p+1, rem_addr base+1024).
- len=3072 with m_desc_ready toggling 1010... -> FIRST/MIDDLE/LAST; outputs stable during stalls; transfer_done once after the third accept.
- loc_psn=0xFFFFFE, len=3000 -> PSNs 0xFFFFFE, 0xFFFFFF, 0x000000; next_psn=0x000001. A second transfer starts at 0x000001, ignoring s_loc_psn.
- s_start_transfer held high 20 cycles -> exactly one transfer. A new edge during ISSUE -> start_dropped pulse, descriptor stream unaffected.
- rst_n low during a MIDDLE stall:
  - next cycle, valid=0 and busy=0.
  - after release, with start held high, there is no retrigger until it falls and rises again.
